// File: rtl/servo_pkg.sv
// Shared definitions for the servo-program ROM sequencer.
//   state_t             : sequencer FSM states
//   SERVOx_MSB/LSB      : bit positions of the three servo fields in a ROM word
//   TIME_MSB/LSB        : bit positions of the hold time (in 20 ms ticks)
//   TICK_CYCLES_DEFAULT : clock cycles per 20 ms tick at 50 MHz
package servo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam int unsigned SERVO1_MSB = 31;
    localparam int unsigned SERVO1_LSB = 24;
    localparam int unsigned SERVO2_MSB = 23;
    localparam int unsigned SERVO2_LSB = 16;
    localparam int unsigned SERVO3_MSB = 15;
    localparam int unsigned SERVO3_LSB = 8;
    localparam int unsigned TIME_MSB   = 7;
    localparam int unsigned TIME_LSB   = 0;

    localparam int unsigned TICK_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/rom_sequencer_tick_timer.sv
// Free-running 20 ms tick generator.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset, counter to 0
//   clear : synchronous clear, counter to 0 on the next edge
//   tick  : 1-cycle pulse while the counter sits at TICK_CYCLES-1
module tick_timer
    import servo_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    // A 1-bit counter is kept for TICK_CYCLES=1; it simply never leaves 0.
    localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/rom_sequencer.sv
// Servo-program ROM sequencer.
// Walks a registered ROM (1-cycle read latency) from address 0, latching the
// three servo positions of each word and holding them for Tiempo 20 ms ticks.
//   CLK      : system clock, rising edge
//   RST      : asynchronous active-high reset
//   Start    : level, begins the program at address 0 from IDLE or DONE
//   Stop     : level, aborts the run and returns to IDLE (has priority)
//   Loop     : wrap to address 0 at program end instead of stopping
//   DataRead : ROM word {Servo1, Servo2, Servo3, Tiempo}
//   Address  : ROM address, registered
//   Servo1-3 : servo positions, registered
//   Busy     : high in FETCH, CAPTURE and HOLD
//   Done     : high in DONE
module rom_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEFAULT,
    parameter int unsigned LAST_ADDR   = 11
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic        Stop,
    input  logic        Loop,
    input  logic [31:0] DataRead,
    output logic [7:0]  Address,
    output logic [7:0]  Servo1,
    output logic [7:0]  Servo2,
    output logic [7:0]  Servo3,
    output logic        Busy,
    output logic        Done
);

    localparam logic [7:0] LAST = 8'(LAST_ADDR);

    state_t     state, state_nx;
    logic [7:0] addr_nx;
    logic [7:0] servo1_nx, servo2_nx, servo3_nx;
    logic [7:0] remain, remain_nx;
    logic       tick_pulse;
    logic       hold_clear;
    logic       take_end;
    logic [7:0] time_field;

    assign time_field = DataRead[TIME_MSB:TIME_LSB];

    // The timer only counts inside HOLD, so every hold starts from tick 0.
    assign hold_clear = (state != ST_HOLD);

    tick_timer #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_timer (
        .clk  (CLK),
        .rst  (RST),
        .clear(hold_clear),
        .tick (tick_pulse)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            Address <= '0;
            Servo1  <= '0;
            Servo2  <= '0;
            Servo3  <= '0;
            remain  <= '0;
        end else begin
            state   <= state_nx;
            Address <= addr_nx;
            Servo1  <= servo1_nx;
            Servo2  <= servo2_nx;
            Servo3  <= servo3_nx;
            remain  <= remain_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        addr_nx   = Address;
        servo1_nx = Servo1;
        servo2_nx = Servo2;
        servo3_nx = Servo3;
        remain_nx = remain;
        take_end  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (Start && !Stop) begin
                    addr_nx  = '0;
                    state_nx = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nx = Stop ? ST_IDLE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (Stop) begin
                    state_nx = ST_IDLE;
                end else if (time_field == 8'd0) begin
                    take_end = 1'b1;
                end else begin
                    servo1_nx = DataRead[SERVO1_MSB:SERVO1_LSB];
                    servo2_nx = DataRead[SERVO2_MSB:SERVO2_LSB];
                    servo3_nx = DataRead[SERVO3_MSB:SERVO3_LSB];
                    remain_nx = time_field;
                    state_nx  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (Stop) begin
                    state_nx = ST_IDLE;
                end else if (tick_pulse) begin
                    remain_nx = remain - 8'd1;
                    if (remain == 8'd1) begin
                        if (Address == LAST) begin
                            take_end = 1'b1;
                        end else begin
                            addr_nx  = Address + 8'd1;
                            state_nx = ST_FETCH;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (Start && !Stop) begin
                    addr_nx  = '0;
                    state_nx = ST_FETCH;
                end else if (Stop) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // End of program: either an end-marker word or expiry of the last word.
        if (take_end) begin
            if (Loop) begin
                addr_nx  = '0;
                state_nx = ST_FETCH;
            end else begin
                state_nx = ST_DONE;
            end
        end
    end

    always_comb begin
        Busy = (state == ST_FETCH) || (state == ST_CAPTURE) || (state == ST_HOLD);
        Done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_rom_sequencer.sv
module tb_rom_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic        Stop = 1'b0;
    logic        Loop = 1'b0;
    logic [31:0] DataRead = '0;
    logic [7:0]  Address, Servo1, Servo2, Servo3;
    logic        Busy, Done;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [12];

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        logic       busy;
        logic       done;
    } snap_t;

    snap_t q[$];
    logic [7:0] p1, p2, p3;

    rom_sequencer #(.TICK_CYCLES(4), .LAST_ADDR(11)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Stop(Stop), .Loop(Loop),
        .DataRead(DataRead), .Address(Address), .Servo1(Servo1),
        .Servo2(Servo2), .Servo3(Servo3), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    // Registered program ROM
    always @(posedge CLK) DataRead <= (Address < 8'd12) ? rom[Address] : 32'h0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Word-level expectation: each word contributes FETCH+CAPTURE (2 cycles, old
    // servos) then 4*Tiempo cycles with the new servos; the list then ends in
    // DONE or restarts at word 0 when looping.
    task automatic build(input int ncyc, input bit lp, input logic [7:0] i1, input logic [7:0] i2, input logic [7:0] i3);
        snap_t s;
        int k;
        bit fin;
        q.delete();
        s.s1 = i1; s.s2 = i2; s.s3 = i3;
        k = 0;
        fin = 1'b0;
        while (q.size() < ncyc && !fin) begin
            s.a = 8'(k); s.busy = 1'b1; s.done = 1'b0;
            q.push_back(s);
            q.push_back(s);
            if (rom[k][7:0] == 8'd0) begin
                fin = 1'b1;
            end else begin
                s.s1 = rom[k][31:24]; s.s2 = rom[k][23:16]; s.s3 = rom[k][15:8];
                repeat (4 * int'(rom[k][7:0])) q.push_back(s);
                if (k == 11) fin = 1'b1;
                else k++;
            end
            if (fin && lp) begin
                fin = 1'b0;
                k = 0;
            end
        end
        s.busy = 1'b0; s.done = 1'b1;
        while (q.size() < ncyc) q.push_back(s);
        while (q.size() > ncyc) void'(q.pop_back());
    endtask

    task automatic chk_snap(input int i);
        chk($sformatf("addr[%0d]", i), Address, q[i].a);
        chk($sformatf("servo1[%0d]", i), Servo1, q[i].s1);
        chk($sformatf("servo2[%0d]", i), Servo2, q[i].s2);
        chk($sformatf("servo3[%0d]", i), Servo3, q[i].s3);
        chk($sformatf("busy[%0d]", i), {7'b0, Busy}, {7'b0, q[i].busy});
        chk($sformatf("done[%0d]", i), {7'b0, Done}, {7'b0, q[i].done});
    endtask

    // Pulse Start for one edge, then compare every cycle against the model.
    task automatic run_seq(input int n, input bit lp);
        build(n, lp, p1, p2, p3);
        Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge CLK); #1;
            end
            chk_snap(i);
        end
        p1 = q[n-1].s1; p2 = q[n-1].s2; p3 = q[n-1].s3;
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] ea);
        chk({tag, "_addr"}, Address, ea);
        chk({tag, "_s1"}, Servo1, p1);
        chk({tag, "_s2"}, Servo2, p2);
        chk({tag, "_s3"}, Servo3, p3);
        chk({tag, "_busy"}, {7'b0, Busy}, 8'd0);
        chk({tag, "_done"}, {7'b0, Done}, 8'd0);
    endtask

    initial begin
        int dly;
        rom[0]  = {8'h00, 8'h00, 8'h00, 8'd100};
        rom[1]  = {8'h3C, 8'h00, 8'h00, 8'd30};
        rom[2]  = {8'h78, 8'h00, 8'h00, 8'd1};
        rom[3]  = {8'hFF, 8'h00, 8'h00, 8'd1};
        rom[4]  = {8'hFF, 8'h3C, 8'h00, 8'd1};
        rom[5]  = {8'hFF, 8'h78, 8'h00, 8'd1};
        rom[6]  = {8'hFF, 8'hFF, 8'h00, 8'd1};
        rom[7]  = {8'hFF, 8'hFF, 8'h3C, 8'd1};
        rom[8]  = {8'hFF, 8'hFF, 8'h78, 8'd1};
        rom[9]  = {8'hFF, 8'hFF, 8'hFF, 8'd1};
        rom[10] = {8'h00, 8'hFF, 8'hFF, 8'd1};
        rom[11] = {8'h00, 8'h00, 8'hFF, 8'd1};
        for (int w = 2; w < 12; w++) rom[w][7:0] = 8'($urandom_range(1, 6));
        p1 = 8'h00; p2 = 8'h00; p3 = 8'h00;

        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        chk_idle("reset", 8'd0);
        RST = 1'b0;
        repeat (2) begin
            @(posedge CLK); #1;
            chk_idle("idle", 8'd0);
        end

        // Scenarios 1 and 2: full run, Loop=0, ends in DONE at address 11
        run_seq(900, 1'b0);
        chk("full_end_s3", Servo3, 8'hFF);
        chk("full_end_addr", Address, 8'd11);

        // Scenario 3: Loop=1 from DONE; Done never rises, then Stop aborts
        Loop = 1'b1;
        run_seq(1700, 1'b1);
        Stop = 1'b1;
        @(posedge CLK); #1;
        chk_idle("loop_stop", q[$].a);
        Stop = 1'b0;
        Loop = 1'b0;

        // Scenario 4: end marker at word 2
        rom[2][7:0] = 8'd0;
        run_seq(600, 1'b0);
        chk("marker_addr", Address, 8'd2);
        chk("marker_s1", Servo1, 8'h3C);
        chk("marker_done", {7'b0, Done}, 8'd1);
        rom[2][7:0] = 8'($urandom_range(1, 6));

        // Scenario 5: Stop at cycle 100 of the word 1 hold (start from DONE)
        run_seq(504, 1'b0);
        Stop = 1'b1;
        @(posedge CLK); #1;
        chk_idle("stop", 8'd1);
        chk("stop_s1", Servo1, 8'h3C);
        Start = 1'b1;
        @(posedge CLK); #1;
        chk_idle("stop_prio", 8'd1);
        Start = 1'b0;
        Stop = 1'b0;
        @(posedge CLK); #1;
        chk_idle("stop_idle", 8'd1);

        // Restart, then asynchronous reset mid-hold of word 0
        run_seq(300, 1'b0);
        dly = int'($urandom_range(2, 5));
        #(dly);
        RST = 1'b1;
        #1;
        p1 = 8'h00; p2 = 8'h00; p3 = 8'h00;
        chk_idle("async_rst", 8'd0);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk_idle("post_rst", 8'd0);

        // Scenario 6 tail: Start behaves as after power-on reset
        run_seq(410, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
